// File: rtl/fifo_pkg.sv
// Shared FIFO constants and elaboration-time helpers.
// Used by the interface, the storage array and the FIFO top level.
package fifo_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Depth must be a power of two so that pointer rollover is plain binary wrap.
    function automatic bit params_ok(input int depth, input int af, input int ae);
        return (depth >= 4) && ((depth & (depth - 1)) == 0) && (ae < af) && (af <= depth);
    endfunction
endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer port bundle for sync_fifo_param.
// The master side drives requests; the slave side is the FIFO.
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);
    localparam int AW = clog2(DEPTH);

    logic              clr;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [AW:0]       count;
    logic              overflow;
    logic              underflow;

    modport master (
        output clr, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
// No reset; contents are only meaningful between the FIFO pointers.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, sticky
// error flags and optional first-word-fall-through output.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter bit FWFT      = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    sync_fifo_param_if.slave   fif
);
    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_AF   = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] CNT_AE   = (AW+1)'(AE_THRESH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    if (!params_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("sync_fifo_param: illegal DEPTH/AF_THRESH/AE_THRESH combination");
    end

    logic [AW:0]       wr_ptr, rd_ptr, count, count_nxt;
    logic              full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
    logic              push, pop;
    logic [DATA_W-1:0] mem_rd;

    // Acceptance uses the registered flags, so WR_EN/RD_EN never reach an output combinationally.
    assign push = fif.wr_en && !full_q;
    assign pop  = fif.rd_en && !empty_q;

    always_comb begin
        count_nxt = count;
        if (push && !pop)      count_nxt = count + ONE;
        else if (pop && !push) count_nxt = count - ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else if (fif.clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE;
            if (pop)  rd_ptr <= rd_ptr + ONE;
            count   <= count_nxt;
            full_q  <= (count_nxt == CNT_FULL);
            empty_q <= (count_nxt == '0);
            af_q    <= (count_nxt >= CNT_AF);
            ae_q    <= (count_nxt <= CNT_AE);
            if (fif.wr_en && full_q)  ovf_q <= 1'b1;
            if (fif.rd_en && empty_q) udf_q <= 1'b1;
        end
    end

    fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (push && !fif.clr),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (fif.wr_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (mem_rd)
    );

    if (FWFT) begin : g_fwft
        // Head word is shown directly; forced to zero when empty so reset/flush leave RD_DATA at 0.
        assign fif.rd_data  = empty_q ? '0 : mem_rd;
        assign fif.rd_valid = !empty_q;
    end else begin : g_reg
        logic [DATA_W-1:0] rd_data_q;
        logic              rd_valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else if (fif.clr) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= pop;
                if (pop) rd_data_q <= mem_rd;
            end
        end

        assign fif.rd_data  = rd_data_q;
        assign fif.rd_valid = rd_valid_q;
    end

    assign fif.full         = full_q;
    assign fif.empty        = empty_q;
    assign fif.almost_full  = af_q;
    assign fif.almost_empty = ae_q;
    assign fif.count        = count;
    assign fif.overflow     = ovf_q;
    assign fif.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one registered-read and one FWFT instance,
// 16x8, AF=14, AE=2, with a queue model for data ordering.
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] mq [$];

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(8), .DEPTH(16)) f0 ();
    sync_fifo_param_if #(.DATA_W(8), .DEPTH(16)) f1 ();

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b0))
        u_reg (.clk(clk), .rst_n(rst_n), .fif(f0));
    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b1))
        u_fwft (.clk(clk), .rst_n(rst_n), .fif(f1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One cycle on the registered-read FIFO, tracked against the queue model.
    task automatic cyc0(input bit w, input logic [7:0] d, input bit r, input string tag);
        bit acc_w, acc_r;
        logic [7:0] exp_d;
        acc_w = w && (mq.size() < 16);
        acc_r = r && (mq.size() > 0);
        exp_d = 8'h00;
        if (acc_r) exp_d = mq.pop_front();
        if (acc_w) mq.push_back(d);
        f0.wr_en = w; f0.wr_data = d; f0.rd_en = r;
        @(posedge clk); #1;
        f0.wr_en = 1'b0; f0.rd_en = 1'b0;
        chk({tag, "_cnt"}, 32'(f0.count), 32'(mq.size()));
        if (acc_r) chk({tag, "_data"}, 32'(f0.rd_data), 32'(exp_d));
        chk({tag, "_vld"}, 32'(f0.rd_valid), 32'(acc_r));
    endtask

    task automatic clr0();
        f0.clr = 1'b1;
        @(posedge clk); #1;
        f0.clr = 1'b0;
        mq.delete();
        chk("clr_cnt", 32'(f0.count), 0);
        chk("clr_ovf", 32'(f0.overflow), 0);
        chk("clr_udf", 32'(f0.underflow), 0);
    endtask

    initial begin
        f0.clr = 0; f0.wr_en = 0; f0.wr_data = 0; f0.rd_en = 0;
        f1.clr = 0; f1.wr_en = 0; f1.wr_data = 0; f1.rd_en = 0;

        // reset state
        #12;
        chk("rst_cnt", 32'(f0.count), 0);
        chk("rst_empty", 32'(f0.empty), 1);
        chk("rst_ae", 32'(f0.almost_empty), 1);
        chk("rst_full", 32'(f0.full), 0);
        chk("rst_af", 32'(f0.almost_full), 0);
        chk("rst_ovf", 32'(f0.overflow), 0);
        chk("rst_udf", 32'(f0.underflow), 0);
        chk("rst_vld", 32'(f0.rd_valid), 0);
        chk("rst_data", 32'(f0.rd_data), 0);
        chk("rst_f1_vld", 32'(f1.rd_valid), 0);
        chk("rst_f1_data", 32'(f1.rd_data), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: fill to full, flags track COUNT
        for (int i = 0; i < 16; i++) begin
            cyc0(1'b1, 8'(i), 1'b0, "t1_push");
            chk("t1_af", 32'(f0.almost_full), 32'(i + 1 >= 14));
            chk("t1_ae", 32'(f0.almost_empty), 32'(i + 1 <= 2));
            chk("t1_full", 32'(f0.full), 32'(i == 15));
        end
        cyc0(1'b1, 8'h77, 1'b0, "t1_over");
        chk("t1_ovf", 32'(f0.overflow), 1);
        chk("t1_full_hold", 32'(f0.full), 1);

        // 2: drain, each pop a single RD_VALID pulse, data held afterwards
        for (int i = 0; i < 16; i++) begin
            cyc0(1'b0, 8'h00, 1'b1, "t2_pop");
            chk("t2_order", 32'(f0.rd_data), 32'(i));
            cyc0(1'b0, 8'h00, 1'b0, "t2_idle");
            chk("t2_hold", 32'(f0.rd_data), 32'(i));
        end
        chk("t2_empty", 32'(f0.empty), 1);
        cyc0(1'b0, 8'h00, 1'b1, "t2_under");
        chk("t2_udf", 32'(f0.underflow), 1);
        clr0();

        // 3: COUNT oscillates 3..10, 38 pushes so both pointers wrap twice
        for (int i = 0; i < 3; i++) cyc0(1'b1, 8'(8'hC0 + i), 1'b0, "t3_pre");
        for (int rep = 0; rep < 5; rep++) begin
            for (int i = 0; i < 7; i++) cyc0(1'b1, 8'(rep * 7 + i + 3), 1'b0, "t3_up");
            chk("t3_hi", 32'(f0.count), 10);
            for (int i = 0; i < 7; i++) cyc0(1'b0, 8'h00, 1'b1, "t3_dn");
            chk("t3_lo", 32'(f0.count), 3);
        end
        for (int i = 0; i < 3; i++) cyc0(1'b0, 8'h00, 1'b1, "t3_drain");
        chk("t3_ovf", 32'(f0.overflow), 0);
        chk("t3_udf", 32'(f0.underflow), 0);
        chk("t3_empty", 32'(f0.empty), 1);

        // 4: simultaneous push+pop at mid, full and empty
        for (int i = 0; i < 8; i++) cyc0(1'b1, 8'(8'h40 + i), 1'b0, "t4_fill");
        cyc0(1'b1, 8'h48, 1'b1, "t4_mid");
        chk("t4_mid_cnt", 32'(f0.count), 8);
        for (int i = 0; i < 8; i++) cyc0(1'b1, 8'(8'h50 + i), 1'b0, "t4_fill2");
        chk("t4_full", 32'(f0.full), 1);
        cyc0(1'b1, 8'hEE, 1'b1, "t4_atfull");
        chk("t4_full_cnt", 32'(f0.count), 15);
        chk("t4_full_ovf", 32'(f0.overflow), 1);
        chk("t4_full_udf", 32'(f0.underflow), 0);
        for (int i = 0; i < 15; i++) cyc0(1'b0, 8'h00, 1'b1, "t4_drain");
        cyc0(1'b1, 8'h99, 1'b1, "t4_atempty");
        chk("t4_empty_cnt", 32'(f0.count), 1);
        chk("t4_empty_udf", 32'(f0.underflow), 1);
        clr0();

        // 5: async reset at COUNT=9 mid-burst
        for (int i = 0; i < 9; i++) cyc0(1'b1, 8'(8'h60 + i), 1'b0, "t5_fill");
        cyc0(1'b0, 8'h00, 1'b1, "t5_pop");
        cyc0(1'b1, 8'h69, 1'b0, "t5_push");
        chk("t5_cnt9", 32'(f0.count), 9);
        f0.wr_en = 1'b1; f0.wr_data = 8'h6A;
        #3 rst_n = 1'b0;
        #1;
        chk("t5_cnt", 32'(f0.count), 0);
        chk("t5_empty", 32'(f0.empty), 1);
        chk("t5_ae", 32'(f0.almost_empty), 1);
        chk("t5_af", 32'(f0.almost_full), 0);
        chk("t5_vld", 32'(f0.rd_valid), 0);
        chk("t5_data", 32'(f0.rd_data), 0);
        f0.wr_en = 1'b0;
        mq.delete();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        cyc0(1'b1, 8'h3C, 1'b0, "t5_newpush");
        cyc0(1'b0, 8'h00, 1'b1, "t5_newpop");
        chk("t5_newdata", 32'(f0.rd_data), 32'h3C);
        chk("t5_empty2", 32'(f0.empty), 1);

        // 6: FWFT instance
        f1.wr_en = 1'b1; f1.wr_data = 8'hA5;
        @(posedge clk); #1;
        f1.wr_en = 1'b0;
        chk("t6_data", 32'(f1.rd_data), 32'hA5);
        chk("t6_vld", 32'(f1.rd_valid), 1);
        chk("t6_cnt", 32'(f1.count), 1);
        f1.rd_en = 1'b1;
        @(posedge clk); #1;
        f1.rd_en = 1'b0;
        chk("t6_empty", 32'(f1.empty), 1);
        chk("t6_vld0", 32'(f1.rd_valid), 0);
        f1.wr_en = 1'b1; f1.wr_data = 8'h11;
        @(posedge clk); #1;
        f1.wr_data = 8'h22;
        @(posedge clk); #1;
        f1.wr_en = 1'b0;
        chk("t6_head1", 32'(f1.rd_data), 32'h11);
        f1.rd_en = 1'b1;
        @(posedge clk); #1;
        chk("t6_head2", 32'(f1.rd_data), 32'h22);
        @(posedge clk); #1;
        @(posedge clk); #1;
        f1.rd_en = 1'b0;
        chk("t6_udf", 32'(f1.underflow), 1);
        chk("t6_cnt0", 32'(f1.count), 0);
        f1.wr_en = 1'b1; f1.wr_data = 8'h33; f1.clr = 1'b1;
        @(posedge clk); #1;
        f1.wr_en = 1'b0; f1.clr = 1'b0;
        chk("t6_clr_cnt", 32'(f1.count), 0);
        chk("t6_clr_udf", 32'(f1.underflow), 0);
        chk("t6_clr_vld", 32'(f1.rd_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
